shift_iter_unit: RTL and testbench
==================================

// Module: shift_iter_unit
// PURPOSE
//  Multi-cycle shifter that performs SLL/SRL/SRA/ROR by one bit per clock under a start/done handshake.
//  It is the sequential counterpart to the single-cycle combinational shifter.
//  The multicycle datapath controller issues it for shift instructions, and divide/normalise sequencing uses it where area matters more than latency.
// PARAMETERS
//  WIDTH  32  data width in bits
//  SHW    5   shift-amount width; equals log2(WIDTH)
// PORTS
//  clk     in   1      single clock; all state updates on its rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; accepted only when busy==0
//  op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled at accept
//  A       in   WIDTH  operand; sampled at accept
//  Shift   in   SHW    shift amount 0..WIDTH-1; sampled at accept
//  busy    out  1      high while an operation is in flight
//  done    out  1      one-cycle pulse; Y is valid from this cycle on
//  Y       out  WIDTH  result; held until the next accept
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, busy=0, done=0, Y=0, count=0.
//  States:
//   - IDLE: start=1 at an edge is the accept. Load data<=A, op_r<=op, count<=Shift. Go to RUN.
//   - RUN, count!=0: apply one step to data, then count<=count-1.
//   - RUN, count==0: Y<=data, done<=1, go to IDLE.
//  Step function (1 bit):
//   - SLL: {d[W-2:0],0}
//   - SRL: {0,d[W-1:1]}
//   - SRA: {d[W-1],d[W-1:1]}
//   - ROR: {d[0],d[W-1:1]}
//   - SRA replicates the sign of the current value. This equals the original A[W-1] for every step.
//  busy and done:
//   - busy = (state==RUN). It is registered-state decode with no combinational path from start.
//   - done is registered and high for exactly one cycle.
//  Latency:
//   - done is high in cycle k+Shift+1 when the accept edge is k.
//   - Shift=0 therefore gives done 1 cycle after accept, with Y=A.
//  Boundary rules:
//   - start while busy=1 is ignored. No queueing, and inputs are not re-sampled.
//   - start in the cycle where done=1 is legal, because state is already IDLE. It is accepted back-to-back.
//   - Y keeps its previous result during a new operation. It changes only at the done edge.
//   - A, Shift and op may change freely after the accept; the operation uses the sampled copies.
//   - rst asserted mid-operation aborts the operation. The next edge restores all reset values, and no done is produced.
//   - rst has priority over start in the same cycle.
//   - Shift=WIDTH-1 is the maximum and takes WIDTH cycles. There is no wrap of count, which stops at 0.
//  Widths:
//   - count is SHW bits.
//   - No arithmetic on data beyond 1-bit concatenation.
// STRUCTURE
//  Package shift_pkg:
//   - op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11
//   - state encoding IDLE/RUN
//   - shared with the combinational shifter and the decoder
//  Sub-module shift_step (combinational): in d, op -> out d_next (one-bit step).
//  Top holds the FSM, count, and the data/Y registers.
// TESTING
//  - SLL:
//     stimulus: A=32'h0000_0001, Shift=4
//     required: Y=32'h0000_0010, done at accept+5, busy high for exactly 5 cycles
//  - SRA:
//     stimulus: A=32'h8000_00F0, Shift=4
//     required: Y=32'hF800_000F
//     same stimulus with SRL: Y=32'h0800_000F
//  - ROR, and Shift=0:
//     stimulus: ROR, A=32'h0000_0003, Shift=1
//     required: Y=32'h8000_0001
//     stimulus: Shift=0, A=32'hDEAD_BEEF
//     required: Y=32'hDEAD_BEEF, done at accept+1
//  - Busy and back-to-back:
//     stimulus: start again while busy with different A
//     required: ignored, first result intact
//     stimulus: start in the done cycle
//     required: accepted, second done at the expected latency
//  - Reset mid-operation:
//     stimulus: rst=1 at accept+3 of a Shift=20 operation
//     required: busy=0, Y=0, done never pulses
//     stimulus: next operation
//     required: correct result
//  - Max shift, against a reference model:
//     stimulus: Shift=31 for all four ops on A=32'h8000_0001
//     required: SLL 32'h8000_0000, SRL 32'h0000_0001, SRA 32'hFFFF_FFFF, ROR 32'h0000_0003
//     required: done at accept+32

Source files
------------

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shifter family: the operation encoding used by
//   the decoder, the combinational shifter and the iterative shifter, and the
//   state encoding of the iterative shifter's controller.
// -----------------------------------------------------------------------------
package shift_pkg;

    // Shift operation encoding as issued by the instruction decoder.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    // Controller states of the iterative shifter.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational single-bit shift/rotate step used by the iterative shifter.
//
//   Ports:
//     i_d       in   WIDTH  current data value
//     i_op      in   2      operation (sh_op_e)
//     o_d_next  out  WIDTH  data value after one 1-bit step
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_d,
    input  sh_op_e           i_op,
    output logic [WIDTH-1:0] o_d_next
);

    always_comb begin
        // NOTE: a default assignment first means every path drives the
        // output, so no latch is inferred if a case arm is ever left out.
        o_d_next = i_d;
        case (i_op)
            SH_SLL:  o_d_next = {i_d[WIDTH-2:0], 1'b0};
            SH_SRL:  o_d_next = {1'b0, i_d[WIDTH-1:1]};
            // The sign bit never changes under a right arithmetic step, so
            // re-using the current MSB keeps the original operand's sign.
            SH_SRA:  o_d_next = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
            SH_ROR:  o_d_next = {i_d[0], i_d[WIDTH-1:1]};
            default: o_d_next = i_d;
        endcase
    end

endmodule : shift_step

// File: rtl/shift_iter_unit.sv
// -----------------------------------------------------------------------------
// shift_iter_unit
//   Multi-cycle shifter: performs SLL/SRL/SRA/ROR one bit per clock under a
//   start/done handshake. Operands are captured at accept; the result appears
//   with a one-cycle done pulse Shift+1 cycles after the accepting edge and is
//   held until the next operation completes.
//
//   Ports:
//     clk    in   1      clock, rising edge
//     rst    in   1      synchronous active-high reset
//     start  in   1      request, accepted only while idle
//     op     in   2      operation (sh_op_e), sampled at accept
//     A      in   WIDTH  operand, sampled at accept
//     Shift  in   SHW    shift amount 0..WIDTH-1, sampled at accept
//     busy   out  1      operation in flight
//     done   out  1      one-cycle completion pulse
//     Y      out  WIDTH  result, held until the next completion
// -----------------------------------------------------------------------------
module shift_iter_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   Shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y
);

    logic [0:0]       r_state;
    logic [SHW-1:0]   r_count;
    logic             r_done;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_data;
    sh_op_e           r_op;
    logic [WIDTH-1:0] w_data_next;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_d      (r_data),
        .i_op     (r_op),
        .o_d_next (w_data_next)
    );

    // Control and result registers. Reset wins over any start in the same
    // cycle, which also aborts an operation without producing a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
            r_y     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here take the
            // value computed from the pre-edge state, regardless of order.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count <= Shift;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // The counter stops at zero: the zero cycle publishes
                    // the result instead of decrementing.
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        r_y     <= r_data;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the working data and captured op are left out of reset: they are
    // always loaded at accept before being used, so a reset adds no meaning.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE) begin
            if (start) begin
                r_data <= A;
                r_op   <= sh_op_e'(op);
            end
        end else if (r_count != '0) begin
            r_data <= w_data_next;
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign Y    = r_y;

endmodule : shift_iter_unit

// File: tb/tb_shift_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_iter_unit
//   Self-checking bench for shift_iter_unit: directed cases plus randomized
//   operations compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [4:0]  Shift;
    logic        busy;
    logic        done;
    logic [31:0] Y;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_y  = 32'h0;

    shift_iter_unit #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .Shift (Shift),
        .busy  (busy),
        .done  (done),
        .Y     (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-amount shift computed directly with SV operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int sh);
        logic [63:0] dbl;
        case (o)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return 32'($signed(a) >>> sh);
            default: begin
                dbl = {a, a} >> sh;
                return dbl[31:0];
            end
        endcase
    endfunction

    // Issue one operation (called at posedge+1) and follow it to done.
    // poke_at >= 0 drives a spurious start with junk inputs at that sample.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [4:0] sh, input logic [31:0] exp_y, input int poke_at);
        int   n;
        int   busy_cycles;
        bit   seen;
        bit   y_moved;
        logic [31:0] held_y;
        held_y = model_y;
        start = 1'b1; op = o; A = a; Shift = sh;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; op = 2'($urandom); Shift = 5'($urandom);
        check({tag, "/busy_after_accept"}, {31'b0, busy}, 32'd1);
        check({tag, "/done_after_accept"}, {31'b0, done}, 32'd0);
        y_moved     = (Y !== held_y);
        busy_cycles = 1;
        n           = 0;
        seen        = 1'b0;
        while (n < 40 && !seen) begin
            if (n == poke_at && n <= int'(sh)) begin
                start = 1'b1; A = $urandom; op = 2'($urandom); Shift = 5'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cycles++;
                if (Y !== held_y) y_moved = 1'b1;
            end
        end
        check({tag, "/latency"}, n, int'(sh) + 1);
        check({tag, "/busy_cycles"}, busy_cycles, int'(sh) + 1);
        check({tag, "/y_held"}, {31'b0, y_moved}, 32'd0);
        check({tag, "/Y"}, Y, exp_y);
        model_y = exp_y;
    endtask

    initial begin
        bit          done_seen;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [4:0]  r_sh;

        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; Shift = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", {31'b0, busy}, 32'd0);
        check("reset/done", {31'b0, done}, 32'd0);
        check("reset/Y", Y, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases; consecutive calls are back-to-back (start in done cycle).
        run_op("sll4",   2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, -1);
        run_op("sra4",   2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, -1);
        run_op("srl4",   2'b01, 32'h8000_00F0, 5'd4,  32'h0800_000F, -1);
        run_op("ror1",   2'b11, 32'h0000_0003, 5'd1,  32'h8000_0001, -1);
        run_op("shift0", 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, -1);
        run_op("busy_ignored", 2'b01, 32'hFFFF_0000, 5'd10, 32'h003F_FFC0, 3);
        run_op("max_sll", 2'b00, 32'h8000_0001, 5'd31, 32'h8000_0000, -1);
        run_op("max_srl", 2'b01, 32'h8000_0001, 5'd31, 32'h0000_0001, -1);
        run_op("max_sra", 2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 5);
        run_op("max_ror", 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003, -1);

        // Reset three edges into a 20-step operation, with start held too.
        start = 1'b1; op = 2'b00; A = 32'h1234_5678; Shift = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b1; A = 32'hFFFF_FFFF; Shift = 5'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("midrst/busy", {31'b0, busy}, 32'd0);
        check("midrst/done", {31'b0, done}, 32'd0);
        check("midrst/Y", Y, 32'h0);
        model_y   = 32'h0;
        done_seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1'b1;
        end
        check("midrst/no_done", {31'b0, done_seen}, 32'd0);
        run_op("after_rst", 2'b10, 32'h9000_0000, 5'd3, 32'hF200_0000, -1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_sh = 5'($urandom);
            run_op($sformatf("rand%0d", i), r_op, r_a, r_sh,
                   ref_shift(r_op, r_a, int'(r_sh)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_iter_unit
